// File: rtl/calc_resp_pkg.sv
// calc_resp_pkg: shared command/response codes, FSM states, FIFO entry and ALU helper.
// Build option CALC_RESP_SHIFT_EN adds the EX_SHIFT state for the serial shifter.
package calc_resp_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef enum logic {
        CAP_IDLE,
        CAP_OP2
    } cap_state_e;

`ifdef CALC_RESP_SHIFT_EN
    typedef enum logic [1:0] {
        EX_IDLE,
        EX_SHIFT,
        EX_OUT
    } ex_state_e;
`else
    typedef enum logic {
        EX_IDLE,
        EX_OUT
    } ex_state_e;
`endif

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] op1;
        logic [31:0] op2;
    } fifo_entry_t;

    typedef struct packed {
        resp_e       resp;
        logic [31:0] data;
    } result_t;

    // Single-cycle commands; anything not add/sub falls through to an error.
    function automatic result_t alu(input fifo_entry_t e);
        result_t     r;
        logic [32:0] sum;
        sum = {1'b0, e.op1} + {1'b0, e.op2};
        r = '{resp: RESP_ERR, data: '0};
        if (e.cmd == CMD_ADD && !sum[32]) r = '{resp: RESP_OK, data: sum[31:0]};
        if (e.cmd == CMD_SUB && e.op2 <= e.op1) r = '{resp: RESP_OK, data: e.op1 - e.op2};
        return r;
    endfunction

endpackage

// File: rtl/calc_resp_if.sv
// calc_resp_if: request and response signals of calc_resp_unit.
interface calc_resp_if;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  req_tag_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        req_drop;

    modport master (
        output req_cmd_in, req_data_in, req_tag_in,
        input  out_resp, out_data, out_tag, req_drop
    );

    modport slave (
        input  req_cmd_in, req_data_in, req_tag_in,
        output out_resp, out_data, out_tag, req_drop
    );
endinterface

// File: rtl/calc_resp_fifo.sv
// calc_resp_fifo: show-ahead request FIFO; a push while full is taken only with a same-cycle pop.
module calc_resp_fifo
    import calc_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  fifo_entry_t wdata_i,
    output fifo_entry_t rdata_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t mem_q [DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic        wr_en;
    logic        rd_en;

    assign full_o  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign empty_o = wr_q == rd_q;
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge c_clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// File: rtl/calc_resp_unit.sv
// calc_resp_unit: captures two-cycle requests, queues them and answers in order.
// Build option: define CALC_RESP_SHIFT_EN for serial shl/shr; otherwise they answer as invalid.
module calc_resp_unit
    import calc_resp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       c_clk,
    input  logic       reset,
    calc_resp_if.slave bus
);
    cap_state_e  cap_q;
    logic [3:0]  cmd_q;
    logic [1:0]  ctag_q;
    logic [31:0] op1_q;
    logic        drop_q;
    ex_state_e   ex_q;
    resp_e       resp_q;
    logic [31:0] data_q;
    logic [1:0]  tag_q;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    fifo_entry_t wr_entry;
    fifo_entry_t head;
    result_t     res;

    assign push     = cap_q == CAP_OP2;
    assign pop      = !empty && (ex_q == EX_IDLE || ex_q == EX_OUT);
    assign wr_entry = '{cmd: cmd_q, tag: ctag_q, op1: op1_q, op2: bus.req_data_in};

    calc_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .c_clk   (c_clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            cap_q  <= CAP_IDLE;
            cmd_q  <= '0;
            ctag_q <= '0;
            op1_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= push && full && !pop;
            if (cap_q == CAP_IDLE && bus.req_cmd_in != CMD_NOP) begin
                cap_q  <= CAP_OP2;
                cmd_q  <= bus.req_cmd_in;
                ctag_q <= bus.req_tag_in;
                op1_q  <= bus.req_data_in;
            end else begin
                cap_q <= CAP_IDLE;
            end
        end
    end

`ifdef CALC_RESP_SHIFT_EN
    logic [31:0] sh_q;
    logic [31:0] sh_d;
    logic [4:0]  cnt_q;
    logic        sh_left_q;
    logic [1:0]  sh_tag_q;
    logic        is_shift;

    assign is_shift = head.cmd == CMD_SHL || head.cmd == CMD_SHR;
    assign sh_d     = sh_left_q ? sh_q << 1 : sh_q >> 1;
    assign res      = is_shift ? result_t'{resp: RESP_OK, data: head.op1} : alu(head);
`else
    assign res = alu(head);
`endif

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            ex_q   <= EX_IDLE;
            resp_q <= RESP_NONE;
            data_q <= '0;
            tag_q  <= '0;
`ifdef CALC_RESP_SHIFT_EN
            sh_q      <= '0;
            cnt_q     <= '0;
            sh_left_q <= 1'b0;
            sh_tag_q  <= '0;
`endif
        end else begin
            resp_q <= RESP_NONE;
            data_q <= '0;
            tag_q  <= '0;
            if (pop) begin
                ex_q   <= EX_OUT;
                resp_q <= res.resp;
                data_q <= res.data;
                tag_q  <= head.tag;
`ifdef CALC_RESP_SHIFT_EN
                sh_q      <= head.op1;
                cnt_q     <= head.op2[4:0];
                sh_left_q <= head.cmd == CMD_SHL;
                sh_tag_q  <= head.tag;
                // Nonzero shift amount defers the response until the last shift step.
                if (is_shift && head.op2[4:0] != 5'd0) begin
                    ex_q   <= EX_SHIFT;
                    resp_q <= RESP_NONE;
                    data_q <= '0;
                    tag_q  <= '0;
                end
`endif
            end
`ifdef CALC_RESP_SHIFT_EN
            else if (ex_q == EX_SHIFT) begin
                sh_q  <= sh_d;
                cnt_q <= cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    ex_q   <= EX_OUT;
                    resp_q <= RESP_OK;
                    data_q <= sh_d;
                    tag_q  <= sh_tag_q;
                end
            end
`endif
            else begin
                ex_q <= EX_IDLE;
            end
        end
    end

    assign bus.out_resp = resp_q;
    assign bus.out_data = data_q;
    assign bus.out_tag  = tag_q;
    assign bus.req_drop = drop_q;
endmodule

// File: tb/tb_calc_resp_unit.sv
// tb_calc_resp_unit: scoreboard bench; expected responses are queued with their due cycle.
module tb_calc_resp_unit;
`ifdef CALC_RESP_SHIFT_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } exp_t;

    logic c_clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   ex_free = 0;
    int   drop_cyc = -1;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    exp_t e;

    calc_resp_if bus ();

    calc_resp_unit #(.FIFO_DEPTH(4)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge c_clk);
        #1;
    endtask

    // n = serial shift cycles the DUT should spend; drop = request expected to be discarded
    task automatic send(input logic [3:0] cmd, input logic [1:0] tag, input logic [31:0] op1,
                        input logic [31:0] op2, input logic [1:0] er, input logic [31:0] ed,
                        input int n, input bit drop);
        int p;
        if (drop) begin
            drop_cyc = cyc + 2;
        end else begin
            p = (cyc + 2 > ex_free) ? cyc + 2 : ex_free;
            ex_free = p + 1 + n;
            sb.push_back('{cyc: ex_free, resp: er, data: ed, tag: tag});
        end
        bus.req_cmd_in  = cmd;
        bus.req_tag_in  = tag;
        bus.req_data_in = op1;
        tick;
        bus.req_cmd_in  = 4'h2;
        bus.req_tag_in  = ~tag;
        bus.req_data_in = op2;
        tick;
        bus.req_cmd_in  = 4'h0;
        bus.req_tag_in  = 2'h0;
        bus.req_data_in = 32'h0;
    endtask

    task automatic drain;
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick;
        chk("drain", 64'(sb.size()), 64'd0);
        repeat (3) tick;
    endtask

    always @(negedge c_clk) begin
        if (mon_en) begin
            chk("drop", 64'(bus.req_drop), 64'(cyc == drop_cyc));
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("resp", 64'(bus.out_resp), 64'(e.resp));
                chk("data", 64'(bus.out_data), 64'(e.data));
                chk("tag", 64'(bus.out_tag), 64'(e.tag));
            end else begin
                chk("idle", 64'({bus.out_resp, bus.out_tag, bus.out_data}), 64'd0);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  t;
        bus.req_cmd_in  = 4'h0;
        bus.req_tag_in  = 2'h0;
        bus.req_data_in = 32'h0;
        tick;
        mon_en = 1'b1;
        repeat (2) tick;
        reset = 1'b1;
        send(4'h1, 2'd1, 32'h56, 32'h103, 2'd1, 32'h159, 0, 1'b0);
        drain;
        send(4'h2, 2'd2, 32'h158, 32'h12, 2'd1, 32'h146, 0, 1'b0);
        send(4'h2, 2'd3, 32'h18, 32'h32, 2'd2, 32'h0, 0, 1'b0);
        send(4'h1, 2'd0, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0, 0, 1'b0);
        send(4'h3, 2'd2, 32'h77, 32'h1, 2'd2, 32'h0, 0, 1'b0);
        send(4'h2, 2'd1, 32'h40, 32'h40, 2'd1, 32'h0, 0, 1'b0);
        drain;
        send(4'h5, 2'd1, 32'h1, 32'h1F, SH ? 2'd1 : 2'd2, SH ? 32'h8000_0000 : 32'h0, SH ? 31 : 0, 1'b0);
        drain;
        send(4'h6, 2'd2, 32'h8000_0000, 32'h4, SH ? 2'd1 : 2'd2, SH ? 32'h0800_0000 : 32'h0, SH ? 4 : 0, 1'b0);
        send(4'h5, 2'd3, 32'h1234, 32'h0, SH ? 2'd1 : 2'd2, SH ? 32'h1234 : 32'h0, 0, 1'b0);
        send(4'h5, 2'd0, 32'h3, 32'hFFFF_FFE2, SH ? 2'd1 : 2'd2, SH ? 32'hC : 32'h0, SH ? 2 : 0, 1'b0);
        drain;
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(0, 32'h00FF_FFFF);
            b = $urandom_range(0, 32'h00FF_FFFF);
            t = 2'($urandom_range(0, 3));
            if (i % 2 == 0) send(4'h1, t, a, b, 2'd1, a + b, 0, 1'b0);
            else send(4'h2, t, a | 32'h0100_0000, b, 2'd1, (a | 32'h0100_0000) - b, 0, 1'b0);
        end
        drain;
        send(4'h5, 2'd2, 32'h3, 32'h1F, SH ? 2'd1 : 2'd2, SH ? 32'h8000_0000 : 32'h0, SH ? 31 : 0, 1'b0);
        send(4'h1, 2'd0, 32'h10, 32'h1, 2'd1, 32'h11, 0, 1'b0);
        send(4'h1, 2'd1, 32'h20, 32'h2, 2'd1, 32'h22, 0, 1'b0);
        send(4'h1, 2'd2, 32'h30, 32'h3, 2'd1, 32'h33, 0, 1'b0);
        send(4'h1, 2'd3, 32'h40, 32'h4, 2'd1, 32'h44, 0, 1'b0);
        send(4'h1, 2'd0, 32'h50, 32'h5, 2'd1, 32'h55, 0, SH);
        drain;
        send(4'h5, 2'd1, 32'h1, 32'h1F, SH ? 2'd1 : 2'd2, SH ? 32'h8000_0000 : 32'h0, SH ? 31 : 0, 1'b0);
        send(4'h1, 2'd2, 32'h1, 32'h1, 2'd1, 32'h2, 0, 1'b0);
        send(4'h1, 2'd3, 32'h2, 32'h2, 2'd1, 32'h4, 0, 1'b0);
        if (SH) begin
            repeat (4) tick;
            sb.delete();
            ex_free = 0;
            reset = 1'b0;
            tick;
            reset = 1'b1;
        end
        send(4'h1, 2'd1, 32'h56, 32'h103, 2'd1, 32'h159, 0, 1'b0);
        drain;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/calc_resp_unit.md
CALC_RESP_UNIT -- requirements
Module: calc_resp_unit

Interface
REQ-001 Parameter SHALL be: FIFO_DEPTH, 4, pending-request FIFO entries (power of two, >=2).
REQ-002 c_clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 req_cmd_in  in  4  command: 0 no-op, 1 add, 2 sub, 5 shl, 6 shr; others invalid.
REQ-005 req_data_in  in  32  operand1 in cmd cycle, operand2 in the following cycle.
REQ-006 req_tag_in  in  2  request tag, sampled in cmd cycle.
REQ-007 out_resp  out  2  0 none, 1 success, 2 error (overflow/underflow/invalid).
REQ-008 out_data  out  32  result; 0 when out_resp is 0 or 2.
REQ-009 out_tag  out  2  tag of the request being answered.
REQ-010 req_drop  out  1  one-cycle pulse when a request is discarded because the FIFO is full.

Function
REQ-011 Capture FSM SHALL have states CAP_IDLE, CAP_OP2: nonzero cmd in CAP_IDLE latches cmd/tag/op1 and moves to CAP_OP2; CAP_OP2 latches op2, returns to CAP_IDLE.
REQ-012 Any req_cmd_in value sampled in CAP_OP2 SHALL be ignored.
REQ-013 Capture SHALL push {cmd,tag,op1,op2} into the FIFO at the edge ending CAP_OP2 (entry visible cycle A+2, A = cmd cycle).
REQ-014 Push with FIFO full and no same-cycle pop SHALL discard the request and pulse req_drop in cycle A+2; push with full and simultaneous pop SHALL be accepted.
REQ-015 Exec FSM SHALL have states EX_IDLE, EX_SHIFT, EX_OUT; pop occurs in EX_IDLE or EX_OUT when FIFO non-empty.
REQ-016 Add/sub/invalid SHALL go from pop directly to EX_OUT; outputs registered, visible cycle after pop (A+3 with empty FIFO).
REQ-017 Add: 33-bit sum; carry-out SHALL give resp 2, data 0, else resp 1, data = sum[31:0].
REQ-018 Sub: op2 > op1 SHALL give resp 2, data 0, else resp 1, data = op1 - op2.
REQ-019 Shl/shr: shift amount n = op2[4:0]; EX_SHIFT SHALL shift op1 one bit per cycle with zero fill, n cycles, then EX_OUT; response visible A+3+n with empty FIFO; resp always 1.
REQ-020 out_resp/out_data/out_tag SHALL be nonzero exactly one cycle per response; 0 in all other cycles.
REQ-021 Responses SHALL be in FIFO (arrival) order; duplicate in-flight tags SHALL be accepted without check.

Reset
REQ-022 reset low at a rising edge SHALL clear capture FSM to CAP_IDLE, exec FSM to EX_IDLE, FIFO to empty, all outputs to 0.
REQ-023 Reset mid-capture or mid-shift SHALL discard the partial/pending requests with no response.
REQ-024 Requests presented in the first cycle with reset high SHALL be accepted normally.

Configuration
REQ-025 Macro CALC_RESP_SHIFT_EN defined: cmds 5/6 execute per REQ-019.
REQ-026 Macro CALC_RESP_SHIFT_EN undefined: EX_SHIFT and shifter SHALL be absent; cmds 5/6 treated as invalid (resp 2, data 0, at A+3).

Structure
REQ-027 Package calc_resp_pkg SHALL hold command codes, response codes (RESP_NONE/OK/ERR), FSM state enums, and the FIFO entry struct.
REQ-028 FIFO SHALL be sub-module calc_resp_fifo (parameterised depth, push/pop/full/empty, simultaneous push+pop).

Verification
REQ-029 Add op1 0x56, op2 0x103, tag 1, empty FIFO -> cycle A+3: resp 1, data 0x159, tag 1; all other cycles resp 0.
REQ-030 Sub 0x158-0x12 tag 2 -> resp 1, data 0x146; sub 0x18-0x32 tag 3 -> resp 2, data 0, tag 3.
REQ-031 Add 0xFFFFFFFF+0x1 -> resp 2, data 0; cmd 0x3 -> resp 2, data 0 at A+3.
REQ-032 Shl 0x1 by 0x1F -> resp 1, data 0x80000000 at A+34; shr 0x80000000 by 4 -> data 0x08000000 at A+7 (macro defined); macro undefined -> both resp 2 at A+3.
REQ-033 Shl by 31 then five back-to-back adds (tags 0..3,0) -> adds 1-4 answered in order after the shift; 5th add dropped, req_drop pulses its cycle A+2, no response.
REQ-034 Reset asserted during EX_SHIFT with 2 queued adds -> all outputs 0 next cycle, no responses for any of the three; next add answered at A+3.
